// File: rtl/drum_step_sequencer_if.sv
// Control/status bundle between the drum sequencer and its host (pushbuttons, tempo, LEDs, voice path).
interface drum_step_sequencer_if #(
  parameter int STEPS   = 8,
  parameter int TRACKS  = 4,
  parameter int TEMPO_W = 8
);
  localparam int SW = $clog2(STEPS);
  localparam int TW = $clog2(TRACKS);

  logic               run;
  logic [TEMPO_W-1:0] tempo_div;
  logic [TW-1:0]      edit_track;
  logic [STEPS-1:0]   step_toggle;
  logic               clear;
  logic [SW-1:0]      step_idx;
  logic [STEPS-1:0]   step_led;
  logic [TRACKS-1:0]  voice_sel;
  logic               voice_active;
  logic [STEPS-1:0]   pattern_row;

  modport master (
    output run, tempo_div, edit_track, step_toggle, clear,
    input  step_idx, step_led, voice_sel, voice_active, pattern_row
  );

  modport slave (
    input  run, tempo_div, edit_track, step_toggle, clear,
    output step_idx, step_led, voice_sel, voice_active, pattern_row
  );
endinterface

// File: rtl/drum_step_sequencer.sv
// Drum pattern sequencer: editable TRACKS x STEPS pattern, tempo-driven stepping,
// and a lowest-index-first single-voice grant held for HOLD cycles per step.
module drum_step_sequencer #(
  parameter int STEPS   = 8,
  parameter int TRACKS  = 4,
  parameter int TEMPO_W = 8,
  parameter int HOLD    = 10
) (
  input  logic                 hz100,
  input  logic                 reset,
  drum_step_sequencer_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  localparam int TW = $clog2(TRACKS);
  localparam int HW = $clog2(HOLD + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;

  logic [0:0]         state;
  logic [SW-1:0]      step_idx;
  logic [TEMPO_W-1:0] cnt;
  logic [TEMPO_W-1:0] div_eff;
  logic [TEMPO_W-1:0] div_next;
  logic [HW-1:0]      hold_cnt;
  logic [TRACKS-1:0]  voice_sel;
  logic [TRACKS-1:0]  grant;
  logic [SW-1:0]      next_col;
  logic               boundary;
  logic               found;
  logic [STEPS-1:0]   pattern [TRACKS];

  // Grant is computed from the pattern as it stands before this edge's edits.
  always_comb begin
    div_next = (bus.tempo_div == '0) ? TEMPO_W'(1) : bus.tempo_div;
    next_col = (state == PLAY) ? step_idx + SW'(1) : '0;
    boundary = (cnt == div_eff - TEMPO_W'(1));
    grant    = '0;
    found    = 1'b0;
    for (int t = 0; t < TRACKS; t++) begin
      if (!found && pattern[t][next_col]) begin
        grant[t] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step_idx  <= '0;
      cnt       <= '0;
      div_eff   <= TEMPO_W'(1);
      hold_cnt  <= '0;
      voice_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.run) begin
            state     <= PLAY;
            step_idx  <= '0;
            cnt       <= '0;
            div_eff   <= div_next;
            voice_sel <= grant;
            hold_cnt  <= HW'(HOLD - 1);
          end
        end
        PLAY: begin
          if (!bus.run) begin
            state     <= IDLE;
            step_idx  <= '0;
            cnt       <= '0;
            hold_cnt  <= '0;
            voice_sel <= '0;
          end else if (boundary) begin
            cnt       <= '0;
            step_idx  <= next_col;
            div_eff   <= div_next;
            voice_sel <= grant;
            hold_cnt  <= HW'(HOLD - 1);
          end else begin
            cnt <= cnt + TEMPO_W'(1);
            if (hold_cnt == '0) voice_sel <= '0;
            else                hold_cnt  <= hold_cnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clear dominates any toggle in the same cycle.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TRACKS; t++) pattern[t] <= '0;
    end else if (bus.clear) begin
      for (int t = 0; t < TRACKS; t++) pattern[t] <= '0;
    end else begin
      for (int t = 0; t < TRACKS; t++) begin
        if (TW'(t) == bus.edit_track) pattern[t] <= pattern[t] ^ bus.step_toggle;
      end
    end
  end

  assign bus.step_idx     = step_idx;
  assign bus.voice_sel    = voice_sel;
  assign bus.voice_active = |voice_sel;
  assign bus.step_led     = (state == PLAY) ? (STEPS'(1) << step_idx) : '0;
  assign bus.pattern_row  = pattern[bus.edit_track];
endmodule
